// File: rtl/msg_stream_pkg.sv
// Shared types and constants for the message stream scheduler.
package msg_stream_pkg;

  typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

  localparam logic [1:0] MSG_GUATEMALA = 2'd0;
  localparam logic [1:0] MSG_QUETZAL   = 2'd1;
  localparam logic [1:0] MSG_ZACAPA    = 2'd2;
  localparam logic [1:0] MSG_TIKAL     = 2'd3;

  localparam logic [3:0] LEN_GUATEMALA = 4'd9;
  localparam logic [3:0] LEN_QUETZAL   = 4'd7;
  localparam logic [3:0] LEN_ZACAPA    = 4'd6;
  localparam logic [3:0] LEN_TIKAL     = 4'd5;

  localparam logic [7:0] NEWLINE_CHAR = 8'h0A;

  function automatic logic [3:0] msg_len(input logic [1:0] msg);
    case (msg)
      MSG_GUATEMALA: msg_len = LEN_GUATEMALA;
      MSG_QUETZAL:   msg_len = LEN_QUETZAL;
      MSG_ZACAPA:    msg_len = LEN_ZACAPA;
      default:       msg_len = LEN_TIKAL;
    endcase
  endfunction

endpackage

// File: rtl/msg_stream_scheduler_rom.sv
// Fixed-text character ROM: (message id, char index) -> ASCII, 8'h00 past the end.
module msg_rom
  import msg_stream_pkg::*;
(
  input  logic [1:0] msg,
  input  logic [3:0] idx,
  output logic [7:0] char_c
);

  always_comb begin
    char_c = 8'h00;
    case (msg)
      MSG_GUATEMALA:
        case (idx)
          4'd0: char_c = "G";
          4'd1: char_c = "u";
          4'd2: char_c = "a";
          4'd3: char_c = "t";
          4'd4: char_c = "e";
          4'd5: char_c = "m";
          4'd6: char_c = "a";
          4'd7: char_c = "l";
          4'd8: char_c = "a";
          default: char_c = 8'h00;
        endcase
      MSG_QUETZAL:
        case (idx)
          4'd0: char_c = "Q";
          4'd1: char_c = "u";
          4'd2: char_c = "e";
          4'd3: char_c = "t";
          4'd4: char_c = "z";
          4'd5: char_c = "a";
          4'd6: char_c = "l";
          default: char_c = 8'h00;
        endcase
      MSG_ZACAPA:
        case (idx)
          4'd0: char_c = "Z";
          4'd1: char_c = "a";
          4'd2: char_c = "c";
          4'd3: char_c = "a";
          4'd4: char_c = "p";
          4'd5: char_c = "a";
          default: char_c = 8'h00;
        endcase
      default:
        case (idx)
          4'd0: char_c = "T";
          4'd1: char_c = "i";
          4'd2: char_c = "k";
          4'd3: char_c = "a";
          4'd4: char_c = "l";
          default: char_c = 8'h00;
        endcase
    endcase
  end

endmodule

// File: rtl/msg_stream_scheduler.sv
// Round-robin scheduler streaming fixed ROM messages over valid/ready.
// Define MSG_STREAM_SCHEDULER_NEWLINE_EN to append a newline terminator carrying out_last.
module msg_stream_scheduler
  import msg_stream_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   msg_sel,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [2:0]          out_src,
  output logic                out_valid,
  output logic [7:0]          out_data,
  output logic                out_last,
  input  logic                out_ready
);

  state_t          state;
  logic [2:0]      rr_ptr;
  logic [1:0]      msg_q;
  logic [3:0]      idx;

  logic            win_found;
  logic [2:0]      win_idx;
  logic [1:0]      win_sel;
  logic [NREQ-1:0] win_onehot;
  logic [1:0]      rom_msg;
  logic [3:0]      rom_idx;
  logic [7:0]      rom_char;
  logic            last_beat;
  logic [2:0]      next_ptr;

  // First requester at or above rr_ptr wins; otherwise the lowest one below it.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_sel    = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i] && (3'(i) >= rr_ptr)) begin
        win_found     = 1'b1;
        win_idx       = 3'(i);
        win_sel       = msg_sel[2*i +: 2];
        win_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[i]) begin
        win_found     = 1'b1;
        win_idx       = 3'(i);
        win_sel       = msg_sel[2*i +: 2];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // ROM looks up the character that will be presented after the coming edge.
  assign rom_msg   = (state == IDLE) ? win_sel : msg_q;
  assign rom_idx   = (state == IDLE) ? 4'd0 : idx + 4'd1;
  assign last_beat = (idx == msg_len(msg_q) - 4'd1);
  assign next_ptr  = (out_src == 3'(NREQ - 1)) ? 3'd0 : out_src + 3'd1;

  msg_rom u_rom (
    .msg    (rom_msg),
    .idx    (rom_idx),
    .char_c (rom_char)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      msg_q     <= '0;
      idx       <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      out_src   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= SEND;
            gnt       <= win_onehot;
            busy      <= 1'b1;
            out_src   <= win_idx;
            msg_q     <= win_sel;
            idx       <= 4'd0;
            out_valid <= 1'b1;
            out_data  <= rom_char;
`ifdef MSG_STREAM_SCHEDULER_NEWLINE_EN
            out_last  <= 1'b0;
`else
            out_last  <= (msg_len(win_sel) == 4'd1);
`endif
          end
        end
        SEND: begin
          if (out_ready) begin
            if (last_beat) begin
              rr_ptr <= next_ptr;
`ifdef MSG_STREAM_SCHEDULER_NEWLINE_EN
              state    <= TERM;
              out_data <= NEWLINE_CHAR;
              out_last <= 1'b1;
`else
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              out_last  <= 1'b0;
`endif
            end else begin
              idx      <= idx + 4'd1;
              out_data <= rom_char;
`ifdef MSG_STREAM_SCHEDULER_NEWLINE_EN
              out_last <= 1'b0;
`else
              out_last <= ((idx + 4'd2) == msg_len(msg_q));
`endif
            end
          end
        end
`ifdef MSG_STREAM_SCHEDULER_NEWLINE_EN
        TERM: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_data  <= 8'h00;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_stream_scheduler.sv
// Randomized self-checking bench for msg_stream_scheduler against a string/queue reference model.
module tb_msg_stream_scheduler;

  localparam int NREQ   = 4;
  localparam int BUDGET = 200;
`ifdef MSG_STREAM_SCHEDULER_NEWLINE_EN
  localparam int NL = 1;
`else
  localparam int NL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] msg_sel = '0;
  logic       out_ready = 1'b1;
  logic [3:0] gnt;
  logic       busy;
  logic [2:0] out_src;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  logic [1:0] sel [4];
  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  msg_stream_scheduler #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .msg_sel   (msg_sel),
    .gnt       (gnt),
    .busy      (busy),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic string msg_text(input int id);
    case (id)
      0:       return "Guatemala";
      1:       return "Quetzal";
      2:       return "Zacapa";
      default: return "Tikal";
    endcase
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic apply_sel();
    msg_sel = {sel[3], sel[2], sel[1], sel[0]};
  endtask

  // Called at a negedge where req is already driven; observes one whole message.
  // mode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
  task automatic serve(input int src, input int id, input int mode, input int drop_after, input string tag);
    string      s;
    int         n, beat, cyc;
    bit         stall;
    logic [7:0] pd, exp;
    logic       pl, exp_last, rdy;
    s = msg_text(id);
    n = s.len() + NL;
    beat = 0; cyc = 0; stall = 0; pd = '0; pl = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'(1 << src) || busy !== 1'b1 || out_src !== 3'(src)) begin
      errors++;
      $display("FAIL %s grant: gnt=%b busy=%b src=%0d, expected gnt=%b busy=1 src=%0d",
               tag, gnt, busy, out_src, 4'(1 << src), src);
    end
    while (beat < n && cyc < BUDGET) begin
      if (cyc > 0) begin
        checks++;
        if (gnt !== 4'b0000) begin
          errors++;
          $display("FAIL %s gnt_pulse: gnt=%b cycle %0d, expected 0000", tag, gnt, cyc);
        end
      end
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_src !== 3'(src)) begin
        errors++;
        $display("FAIL %s active: valid=%b busy=%b src=%0d beat %0d, expected 1 1 %0d",
                 tag, out_valid, busy, out_src, beat, src);
      end
      if (stall) begin
        checks++;
        if (out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL %s hold: data=%h last=%b, expected %h %b", tag, out_data, out_last, pd, pl);
        end
      end
      exp = (beat < s.len()) ? s[beat] : 8'h0A;
      exp_last = (beat == n - 1);
      checks++;
      if (out_data !== exp || out_last !== exp_last) begin
        errors++;
        $display("FAIL %s beat %0d: data=%h last=%b, expected %h %b",
                 tag, beat, out_data, out_last, exp, exp_last);
      end
      if (beat == drop_after) req[src] = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      stall = !rdy;
      pd = out_data;
      pl = out_last;
      if (rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= BUDGET) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d of %0d beats delivered", tag, beat, n);
    end
    model_ptr = (src + 1) % NREQ;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s gap: busy=%b valid=%b last=%b, expected 0 0 0", tag, busy, out_valid, out_last);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || out_src !== 3'd0) begin
      errors++;
      $display("FAIL reset ctrl: gnt=%b busy=%b src=%0d, expected 0 0 0", gnt, busy, out_src);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset data: valid=%b data=%h last=%b, expected 0 00 0", out_valid, out_data, out_last);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) sel[i] = 2'd2;
    apply_sel();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        serve(0, 2, 0, 0, "round_robin");
        req = 4'b0000;
      end else begin
        serve(k, 2, 0, -1, "round_robin");
      end
    end
  endtask

  task automatic test_single();
    sel[2] = 2'd3;
    apply_sel();
    req = 4'b0100;
    serve(2, 3, 0, 2, "single");
  endtask

  task automatic test_backpressure();
    sel[0] = 2'd0;
    apply_sel();
    req = 4'b0001;
    serve(0, 0, 1, 0, "backpressure");
    out_ready = 1'b1;
  endtask

  task automatic test_req_drop();
    sel[1] = 2'd1;
    apply_sel();
    req = 4'b0010;
    serve(1, 1, 0, 2, "req_drop");
  endtask

  task automatic test_reset_mid();
    sel[0] = 2'd0;
    apply_sel();
    out_ready = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid grant: gnt=%b, expected 0001", gnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_data !== 8'h65 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid beat4: data=%h valid=%b, expected 65 1", out_data, out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid abort: busy=%b valid=%b data=%h last=%b src=%0d, expected 0 0 00 0 0",
               busy, out_valid, out_data, out_last, out_src);
    end
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    sel[0] = 2'd0;
    sel[3] = 2'd3;
    apply_sel();
    req = 4'b1001;
    serve(rr_pick(req, model_ptr), 0, 0, 0, "reset_rr_ptr");
    serve(3, 3, 0, 0, "reset_next");
    req = 4'b0000;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int w;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          sel[i] = 2'($urandom_range(0, 3));
        end
      end
      apply_sel();
      if (req == 4'b0000) begin
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
          errors++;
          $display("FAIL random idle: gnt=%b busy=%b, expected 0000 0", gnt, busy);
        end
      end else begin
        w = rr_pick(req, model_ptr);
        serve(w, int'(sel[w]), 2, 0, "random");
      end
    end
    req = 4'b0000;
    out_ready = 1'b1;
  endtask

  task automatic test_idle();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle: gnt=%b busy=%b valid=%b, expected 0000 0 0", gnt, busy, out_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sel[i] = 2'd0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_req_drop();
    test_reset_mid();
    test_random();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
